// File: rtl/fpu_add_pkg.sv
// Shared widths and payload types for the FP32 adder normalisation stage.
package fpu_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned SUM_W   = MAN_W + 5;
  localparam int unsigned MANT_W  = MAN_W + 4;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] sum;
  } norm_in_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              ovf;
    logic              unf;
  } norm_out_t;

endpackage

// File: rtl/fpu_add_norm_stage_if.sv
// Upstream/downstream handshake and payload bundle; signal names follow the stage's own view.
interface fpu_add_norm_stage_if;
  import fpu_add_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic              i_sign;
  logic [EXP_W-1:0]  i_exp;
  logic [SUM_W-1:0]  i_sum;
  logic              o_valid;
  logic              i_ready;
  logic              o_sign;
  logic [EXP_W-1:0]  o_exp;
  logic [MANT_W-1:0] o_mant;
  logic              o_zero;
  logic              o_ovf;
  logic              o_unf;

  modport slave (
    input  i_valid, i_sign, i_exp, i_sum, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_ovf, o_unf
  );

  modport master (
    output i_valid, i_sign, i_exp, i_sum, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_ovf, o_unf
  );

endinterface

// File: rtl/fpu_add_lzc28.sv
// 28-bit leading-zero counter: seven 4-bit leading-one cells and a nibble priority combiner.
module fpu_add_lzc28 (
  input  logic [27:0] i_data,
  output logic [4:0]  o_lz,
  output logic        o_zero
);

  logic [6:0]      w_nib_any;
  logic [6:0][1:0] w_nib_cnt;

  // Cell 0 covers the most significant nibble.
  for (genvar g = 0; g < 7; g++) begin : g_cell
    logic [3:0] w_nib;
    assign w_nib        = i_data[27-4*g -: 4];
    assign w_nib_any[g] = |w_nib;
    assign w_nib_cnt[g] = w_nib[3] ? 2'd0 :
                          w_nib[2] ? 2'd1 :
                          w_nib[1] ? 2'd2 : 2'd3;
  end

  always_comb begin
    o_lz = 5'd28;
    for (int i = 6; i >= 0; i--) begin
      if (w_nib_any[i]) o_lz = 5'(4 * i) + {3'b000, w_nib_cnt[i]};
    end
    o_zero = ~|w_nib_any;
  end

endmodule

// File: rtl/fpu_add_norm_stage.sv
// Post-add normalisation: S1 registers the raw sum with its leading-zero count,
// S2 registers the shifted mantissa, adjusted exponent and zero/overflow/underflow flags.
module fpu_add_norm_stage
  import fpu_add_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_rst_n,
  input logic                 i_flush,
  fpu_add_norm_stage_if.slave bus
);

  logic      w_adv1, w_adv2;
  logic [4:0] w_lz;
  logic      w_zero;

  logic      r_s1_valid;
  norm_in_t  r_s1_in;
  logic [4:0] r_s1_lz;
  logic      r_s1_zero;

  logic      r_s2_valid;
  norm_out_t r_s2_out;
  norm_out_t w_s2_nxt;

  logic [4:0]        w_shamt;
  logic [MANT_W-1:0] w_shl;
  logic [EXP_W:0]    w_exp_inc;

  assign w_adv2      = ~r_s2_valid | bus.i_ready;
  assign w_adv1      = ~r_s1_valid | w_adv2;
  assign bus.o_ready = w_adv1;

  fpu_add_lzc28 u_lzc (
    .i_data (bus.i_sum),
    .o_lz   (w_lz),
    .o_zero (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= '0;
      r_s1_lz    <= '0;
      r_s1_zero  <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_s1_in   <= '{sign: bus.i_sign, exp: bus.i_exp, sum: bus.i_sum};
        r_s1_lz   <= w_lz;
        r_s1_zero <= w_zero;
      end
    end
  end

  // lz counts from the carry bit, so lz==1 is already normalised and lz-1 is the left shift.
  assign w_shamt   = r_s1_lz - 5'd1;
  assign w_shl     = r_s1_in.sum[MANT_W-1:0] << w_shamt;
  assign w_exp_inc = {1'b0, r_s1_in.exp} + (EXP_W + 1)'(1);

  always_comb begin
    w_s2_nxt      = '0;
    w_s2_nxt.sign = r_s1_in.sign;
    if (r_s1_zero) begin
      w_s2_nxt.sign = 1'b0;
      w_s2_nxt.zero = 1'b1;
    end else if (r_s1_in.exp == '0) begin
      w_s2_nxt.unf = 1'b1;
    end else if (r_s1_lz == 5'd0) begin
      if (w_exp_inc >= (EXP_W + 1)'(EXP_MAX)) begin
        w_s2_nxt.ovf = 1'b1;
        w_s2_nxt.exp = '1;
      end else begin
        w_s2_nxt.exp  = w_exp_inc[EXP_W-1:0];
        w_s2_nxt.mant = {r_s1_in.sum[SUM_W-1:2], r_s1_in.sum[1] | r_s1_in.sum[0]};
      end
    end else if (r_s1_lz == 5'd1) begin
      w_s2_nxt.exp  = r_s1_in.exp;
      w_s2_nxt.mant = r_s1_in.sum[MANT_W-1:0];
    end else if (r_s1_in.exp > EXP_W'(w_shamt)) begin
      w_s2_nxt.exp  = r_s1_in.exp - EXP_W'(w_shamt);
      w_s2_nxt.mant = w_shl;
    end else begin
      w_s2_nxt.unf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_out   <= '0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_out <= w_s2_nxt;
    end
  end

  assign bus.o_valid = r_s2_valid;
  assign bus.o_sign  = r_s2_out.sign;
  assign bus.o_exp   = r_s2_out.exp;
  assign bus.o_mant  = r_s2_out.mant;
  assign bus.o_zero  = r_s2_out.zero;
  assign bus.o_ovf   = r_s2_out.ovf;
  assign bus.o_unf   = r_s2_out.unf;

endmodule

// File: tb/tb_fpu_add_norm_stage.sv
// Directed self-checking bench for the adder normalisation stage.
module tb_fpu_add_norm_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_fail;

  fpu_add_norm_stage_if bus ();

  fpu_add_norm_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at #1 after a rising edge; flags are {zero, ovf, unf}.
  task automatic send_one(input string tag, input logic sign, input logic [7:0] exp,
                          input logic [27:0] sum, input logic e_sign, input logic [7:0] e_exp,
                          input logic [26:0] e_mant, input logic [2:0] e_flags);
    int n;
    chk({tag, ":rdy"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_sign  = sign;
    bus.i_exp   = exp;
    bus.i_sum   = sum;
    tick();
    bus.i_valid = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, ":lat"}, 32'(n), 32'd1);
    chk({tag, ":sign"}, 32'(bus.o_sign), 32'(e_sign));
    chk({tag, ":exp"}, 32'(bus.o_exp), 32'(e_exp));
    chk({tag, ":mant"}, 32'(bus.o_mant), 32'(e_mant));
    chk({tag, ":flags"}, 32'({bus.o_zero, bus.o_ovf, bus.o_unf}), 32'(e_flags));
    tick();
  endtask

  initial begin
    int sent, got, seen;
    bit dropped, held;
    logic [31:0] h_exp, h_mant;

    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_sum   = '0;
    bus.i_ready = 1'b1;
    #1;
    chk("rst:o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst:o_ready", 32'(bus.o_ready), 32'd1);
    chk("rst:o_exp", 32'(bus.o_exp), 32'd0);
    chk("rst:o_mant", 32'(bus.o_mant), 32'd0);
    chk("rst:flags", 32'({bus.o_zero, bus.o_ovf, bus.o_unf}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    send_one("norm",     1'b0, 8'd127, 28'h4000000, 1'b0, 8'd127, 27'h4000000, 3'b000);
    send_one("carry",    1'b0, 8'd127, 28'h8000001, 1'b0, 8'd128, 27'h4000001, 3'b000);
    send_one("canc",     1'b1, 8'd127, 28'h0000100, 1'b1, 8'd109, 27'h4000000, 3'b000);
    send_one("unf",      1'b1, 8'd10,  28'h0000100, 1'b1, 8'd0,   27'h0,       3'b001);
    send_one("ovf",      1'b1, 8'd254, 28'h8000000, 1'b1, 8'hFF,  27'h0,       3'b010);
    send_one("zero",     1'b1, 8'd77,  28'h0000000, 1'b0, 8'd0,   27'h0,       3'b100);
    send_one("grs",      1'b0, 8'd100, 28'h0123457, 1'b0, 8'd94,  27'h48D15C0, 3'b000);
    send_one("exp0",     1'b0, 8'd0,   28'h4000000, 1'b0, 8'd0,   27'h0,       3'b001);
    send_one("edge_unf", 1'b0, 8'd18,  28'h0000100, 1'b0, 8'd0,   27'h0,       3'b001);
    send_one("edge_ok",  1'b1, 8'd19,  28'h0000100, 1'b1, 8'd1,   27'h4000000, 3'b000);
    send_one("c253",     1'b0, 8'd253, 28'hC000006, 1'b0, 8'd254, 27'h6000003, 3'b000);
    send_one("lsb",      1'b0, 8'd200, 28'h0000001, 1'b0, 8'd174, 27'h4000000, 3'b000);

    // Five back-to-back transfers with the consumer stalled on cycles 2-4.
    sent    = 0;
    got     = 0;
    dropped = 1'b0;
    held    = 1'b0;
    h_exp   = '0;
    h_mant  = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      bus.i_ready = !(c >= 2 && c <= 4);
      bus.i_valid = (sent < 5);
      bus.i_sign  = sent[0];
      bus.i_exp   = 8'(20 + 10 * sent);
      bus.i_sum   = 28'h4000000 | 28'(sent);
      #1;
      if (sent < 5 && !bus.o_ready) dropped = 1'b1;
      if (held && bus.o_valid) begin
        chk("b2b:hold_exp", 32'(bus.o_exp), h_exp);
        chk("b2b:hold_mant", 32'(bus.o_mant), h_mant);
      end
      held = 1'b0;
      if (bus.o_valid) begin
        if (bus.i_ready) begin
          chk("b2b:exp", 32'(bus.o_exp), 32'(20 + 10 * got));
          chk("b2b:mant", 32'(bus.o_mant), 32'h4000000 | 32'(got));
          chk("b2b:sign", 32'(bus.o_sign), 32'(got & 1));
          got++;
        end else begin
          held   = 1'b1;
          h_exp  = 32'(bus.o_exp);
          h_mant = 32'(bus.o_mant);
        end
      end
      if (bus.i_valid && bus.o_ready) sent++;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk("b2b:count", 32'(got), 32'd5);
    chk("b2b:ready_drop", 32'(dropped), 32'd1);
    tick();

    // Flush with two results in flight; the same-cycle input must also vanish.
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_exp   = 8'd50;
    bus.i_sum   = 28'h4000000;
    tick();
    tick();
    chk("flush:pre_valid", 32'(bus.o_valid), 32'd1);
    chk("flush:pre_ready", 32'(bus.o_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush       = 1'b0;
    bus.i_valid = 1'b0;
    chk("flush:o_valid", 32'(bus.o_valid), 32'd0);
    chk("flush:o_ready", 32'(bus.o_ready), 32'd1);
    bus.i_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.o_valid) seen++;
      tick();
    end
    chk("flush:no_ghost", 32'(seen), 32'd0);

    // Asynchronous reset while stalled.
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    tick();
    tick();
    bus.i_valid = 1'b0;
    chk("arst:pre_valid", 32'(bus.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst:o_valid", 32'(bus.o_valid), 32'd0);
    chk("arst:o_ready", 32'(bus.o_ready), 32'd1);
    tick();
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    chk("arst:post_valid", 32'(bus.o_valid), 32'd0);
    send_one("recover", 1'b0, 8'd60, 28'h2000000, 1'b0, 8'd59, 27'h4000000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
